uart_reg_bank: RTL and testbench
================================

UART_REG_BANK -- requirements
Module: uart_reg_bank

Interface
Parameters: name, default, meaning.
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, CPU word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register and bus width; it is a multiple of 8.
REQ-003 The block SHALL have parameter REG_COUNT, default 6, number of registers; 1 <= REG_COUNT <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameters RW_MASKS, RC_MASKS and RST_VALUES, each REG_COUNT*DATA_WIDTH bits, default all zero, giving per-register CPU-writable bits, read-clear bits and reset values; register n occupies slice [n*DATA_WIDTH +: DATA_WIDTH].
REQ-005 The block SHALL have parameters IRQ_STAT_IDX, default 0, and IRQ_MASK_IDX, default 4, the interrupt status and mask register indices.
Ports: name  direction  width  meaning.
REQ-006 The block SHALL have these ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, synchronous, active-low
- cpu_addr_i  in  ADDR_WIDTH  register index
- cpu_data_i  in  DATA_WIDTH  write data
- cpu_be_i  in  DATA_WIDTH/8  byte enables
- cpu_wr_en_i  in  1  write request
- cpu_rd_en_i  in  1  read request
- cpu_data_o  out  DATA_WIDTH  registered read data
- cpu_rvalid_o  out  1  read data valid pulse
- cpu_err_o  out  1  access error pulse
- periph_data_i  in  REG_COUNT*DATA_WIDTH  peripheral write data
- periph_wr_en_i  in  REG_COUNT  per-register peripheral write enables
- periph_data_o  out  REG_COUNT*DATA_WIDTH  all register contents
- rd_strobe_o  out  REG_COUNT  one-hot pulse, register n read
- wr_strobe_o  out  REG_COUNT  one-hot pulse, register n written by CPU
- irq_o  out  1  interrupt

Function
REQ-007 Every bit SHALL update on clk_i with this priority, highest first:
- CPU write, bit in RW_MASKS and its byte enabled -> cpu_data_i;
- else periph_wr_en_i[n] -> periph_data_i bit;
- else CPU read of n and bit in RC_MASKS -> 0;
- else hold.
REQ-008 CPU writes SHALL never change bits outside RW_MASKS.
REQ-009 Read latency SHALL be exactly 1 cycle: a read accepted at edge T drives cpu_data_o and cpu_rvalid_o=1 for the cycle after T, with cpu_data_o holding the pre-clear, pre-write value.
REQ-010 Read-clear SHALL take effect at the same edge T.
REQ-011 cpu_data_o SHALL hold its last value while cpu_rvalid_o=0.
REQ-012 rd_strobe_o[n] and wr_strobe_o[n] SHALL be registered single-cycle pulses aligned with cpu_rvalid_o, and with the write taking effect, respectively.
REQ-013 An address >= REG_COUNT SHALL be an error:
- writes are ignored;
- reads return 0 with cpu_rvalid_o=1;
- cpu_err_o pulses 1 cycle after the request;
- no strobe fires.
REQ-014 Simultaneous cpu_rd_en_i and cpu_wr_en_i SHALL both execute; the read returns the pre-write value.
REQ-015 Back-to-back reads every cycle SHALL be supported at full throughput; no stall exists.

Reset
REQ-016 While rst_ni=0 at a clock edge, register n SHALL load its RST_VALUES slice.
REQ-017 While rst_ni=0 at a clock edge, cpu_data_o, cpu_rvalid_o, cpu_err_o, both strobe vectors and irq_o SHALL load 0.
REQ-018 A read in flight during reset SHALL be discarded; no rvalid follows reset release.

Configuration
REQ-019 With UART_REG_IRQ_EN defined, irq_o SHALL be the registered value of OR(reg[IRQ_STAT_IDX] & reg[IRQ_MASK_IDX]), 1 cycle after the contributing register changes.
REQ-020 Without UART_REG_IRQ_EN, irq_o SHALL be tied 0 and no interrupt logic SHALL be synthesised; the port remains.

Structure
REQ-021 Package uart_reg_pkg SHALL hold the register index constants (STAT=0, CTRL=1, TX=2, RX=3, IRQ_MASK=4, BAUD=5) and the default UART mask and reset-value constants.
REQ-022 Sub-module uart_reg_cell SHALL implement one register with the REQ-007 priority and SHALL be generated REG_COUNT times.

Verification
REQ-023 Bench SHALL cover: reset with RST_VALUES[1]=0x0000_0100 -> periph_data_o slice 1 = 0x100; cpu_rvalid_o=0; irq_o=0.
REQ-024 Bench SHALL cover: write 0xFFFF_FFFF, be=4'b0001, addr 1, RW mask 0xC37D037F -> reg1 = 0x0000_007F; wr_strobe_o=6'b000010 for 1 cycle.
REQ-025 Bench SHALL cover: reg0=0x0001_0001, RC mask 0x10001, read addr 0 -> cpu_data_o=0x0001_0001 next cycle; reg0=0.
REQ-026 Bench SHALL cover: same-edge read-clear of reg0 and periph write 0x1 to reg0 -> reg0=0x1.
REQ-027 Bench SHALL cover: read addr 7 with REG_COUNT=6 -> cpu_data_o=0; cpu_rvalid_o=1; cpu_err_o=1; rd_strobe_o=0.
REQ-028 Bench SHALL cover, with UART_REG_IRQ_EN: reg4=0x1, then periph write 0x1 to reg0 -> irq_o=1 one cycle later; read-clear of reg0 -> irq_o=0 one cycle after the clear.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// rtl/uart_reg_pkg.sv - UART register indices and default mask/reset-value constants
package uart_reg_pkg;

    localparam int STAT     = 0;
    localparam int CTRL     = 1;
    localparam int TX       = 2;
    localparam int RX       = 3;
    localparam int IRQ_MASK = 4;
    localparam int BAUD     = 5;

    localparam int UART_REG_COUNT  = 6;
    localparam int UART_DATA_WIDTH = 32;

    // Concatenations list register 5 (BAUD) first, register 0 (STAT) last.
    localparam logic [UART_REG_COUNT*UART_DATA_WIDTH-1:0] UART_RW_MASKS = {
        32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000,
        32'h0000_00FF, 32'hC37D_037F, 32'h0000_0000
    };
    localparam logic [UART_REG_COUNT*UART_DATA_WIDTH-1:0] UART_RC_MASKS = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0001_0001
    };
    localparam logic [UART_REG_COUNT*UART_DATA_WIDTH-1:0] UART_RST_VALUES = {
        32'h0000_001B, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0100, 32'h0000_0000
    };

endpackage

// File: rtl/uart_reg_bank_if.sv
// rtl/uart_reg_bank_if.sv - CPU register-access bus with master/slave views
interface uart_reg_bank_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic [DATA_WIDTH/8-1:0] cpu_be;
    logic                    cpu_wr_en;
    logic                    cpu_rd_en;
    logic [DATA_WIDTH-1:0]   cpu_rdata;
    logic                    cpu_rvalid;
    logic                    cpu_err;

    modport master (
        output cpu_addr, cpu_wdata, cpu_be, cpu_wr_en, cpu_rd_en,
        input  cpu_rdata, cpu_rvalid, cpu_err
    );
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_be, cpu_wr_en, cpu_rd_en,
        output cpu_rdata, cpu_rvalid, cpu_err
    );
endinterface

// File: rtl/uart_reg_cell.sv
// rtl/uart_reg_cell.sv - one register: CPU write > peripheral write > read-clear > hold
module uart_reg_cell
    import uart_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RW_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RC_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_cpu_wr,
    input  logic [DATA_WIDTH-1:0] i_cpu_bits,
    input  logic [DATA_WIDTH-1:0] i_cpu_data,
    input  logic                  i_rd_clr,
    input  logic                  i_periph_wr,
    input  logic [DATA_WIDTH-1:0] i_periph_data,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] w_next;
    logic [DATA_WIDTH-1:0] w_cpu_bits;

    // Apply sources lowest priority first so later ones override.
    always_comb begin
        w_cpu_bits = RW_MASK & i_cpu_bits & {DATA_WIDTH{i_cpu_wr}};
        w_next     = r_q;
        if (i_rd_clr) begin
            w_next = w_next & ~RC_MASK;
        end
        if (i_periph_wr) begin
            w_next = i_periph_data;
        end
        w_next = (w_next & ~w_cpu_bits) | (i_cpu_data & w_cpu_bits);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= RST_VALUE;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_reg_bank.sv
// rtl/uart_reg_bank.sv - UART register bank with CPU and peripheral access; UART_REG_IRQ_EN enables irq_o
module uart_reg_bank
    import uart_reg_pkg::*;
#(
    parameter int                               ADDR_WIDTH   = 3,
    parameter int                               DATA_WIDTH   = 32,
    parameter int                               REG_COUNT    = 6,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]  RW_MASKS     = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]  RC_MASKS     = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]  RST_VALUES   = '0,
    parameter int                               IRQ_STAT_IDX = 0,
    parameter int                               IRQ_MASK_IDX = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]            cpu_data_i,
    input  logic [DATA_WIDTH/8-1:0]          cpu_be_i,
    input  logic                             cpu_wr_en_i,
    input  logic                             cpu_rd_en_i,
    output logic [DATA_WIDTH-1:0]            cpu_data_o,
    output logic                             cpu_rvalid_o,
    output logic                             cpu_err_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0]  periph_data_i,
    input  logic [REG_COUNT-1:0]             periph_wr_en_i,
    output logic [REG_COUNT*DATA_WIDTH-1:0]  periph_data_o,
    output logic [REG_COUNT-1:0]             rd_strobe_o,
    output logic [REG_COUNT-1:0]             wr_strobe_o,
    output logic                             irq_o
);
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] w_regs;
    logic [REG_COUNT-1:0]                 w_sel;
    logic                                 w_addr_ok;
    logic [DATA_WIDTH-1:0]                w_rd_data;
    logic [DATA_WIDTH-1:0]                w_be_bits;

    logic [DATA_WIDTH-1:0]                r_rdata;
    logic                                 r_rvalid;
    logic                                 r_err;
    logic [REG_COUNT-1:0]                 r_rd_strobe;
    logic [REG_COUNT-1:0]                 r_wr_strobe;

    // Out-of-range addresses select nothing, which is what flags the error.
    always_comb begin
        w_sel     = '0;
        w_rd_data = '0;
        w_be_bits = '0;
        for (int n = 0; n < REG_COUNT; n++) begin
            w_sel[n] = (cpu_addr_i == ADDR_WIDTH'(n));
            if (w_sel[n]) begin
                w_rd_data = w_regs[n];
            end
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_be_bits[i] = cpu_be_i[i/8];
        end
        w_addr_ok = |w_sel;
    end

    for (genvar n = 0; n < REG_COUNT; n++) begin : g_reg
        uart_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .RW_MASK    (RW_MASKS[n*DATA_WIDTH +: DATA_WIDTH]),
            .RC_MASK    (RC_MASKS[n*DATA_WIDTH +: DATA_WIDTH]),
            .RST_VALUE  (RST_VALUES[n*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .i_cpu_wr      (cpu_wr_en_i & w_sel[n]),
            .i_cpu_bits    (w_be_bits),
            .i_cpu_data    (cpu_data_i),
            .i_rd_clr      (cpu_rd_en_i & w_sel[n]),
            .i_periph_wr   (periph_wr_en_i[n]),
            .i_periph_data (periph_data_i[n*DATA_WIDTH +: DATA_WIDTH]),
            .o_q           (w_regs[n])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_rd_strobe <= '0;
            r_wr_strobe <= '0;
        end else begin
            r_rvalid    <= cpu_rd_en_i;
            r_err       <= (cpu_rd_en_i | cpu_wr_en_i) & ~w_addr_ok;
            r_rd_strobe <= w_sel & {REG_COUNT{cpu_rd_en_i}};
            r_wr_strobe <= w_sel & {REG_COUNT{cpu_wr_en_i}};
            if (cpu_rd_en_i) begin
                r_rdata <= w_rd_data;
            end
        end
    end

`ifdef UART_REG_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_regs[IRQ_STAT_IDX] & w_regs[IRQ_MASK_IDX]);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    assign cpu_data_o    = r_rdata;
    assign cpu_rvalid_o  = r_rvalid;
    assign cpu_err_o     = r_err;
    assign rd_strobe_o   = r_rd_strobe;
    assign wr_strobe_o   = r_wr_strobe;
    assign periph_data_o = w_regs;
endmodule

// File: tb/tb_uart_reg_bank.sv
// tb/tb_uart_reg_bank.sv - self-checking bench for uart_reg_bank against a behavioural register model
module tb_uart_reg_bank;
    import uart_reg_pkg::*;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int RC = 6;
    localparam logic [RC-1:0][DW-1:0] RW_M  = UART_RW_MASKS;
    localparam logic [RC-1:0][DW-1:0] RC_M  = UART_RC_MASKS;
    localparam logic [RC-1:0][DW-1:0] RST_V = UART_RST_VALUES;
`ifdef UART_REG_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic [RC-1:0][DW-1:0] p_data;
    logic [RC-1:0][DW-1:0] regs_o;
    logic [RC-1:0]         p_we;
    logic [RC-1:0]         rd_stb;
    logic [RC-1:0]         wr_stb;
    logic                  irq;

    uart_reg_bank #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .REG_COUNT    (RC),
        .RW_MASKS     (UART_RW_MASKS),
        .RC_MASKS     (UART_RC_MASKS),
        .RST_VALUES   (UART_RST_VALUES),
        .IRQ_STAT_IDX (STAT),
        .IRQ_MASK_IDX (IRQ_MASK)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cpu_addr_i     (bus.cpu_addr),
        .cpu_data_i     (bus.cpu_wdata),
        .cpu_be_i       (bus.cpu_be),
        .cpu_wr_en_i    (bus.cpu_wr_en),
        .cpu_rd_en_i    (bus.cpu_rd_en),
        .cpu_data_o     (bus.cpu_rdata),
        .cpu_rvalid_o   (bus.cpu_rvalid),
        .cpu_err_o      (bus.cpu_err),
        .periph_data_i  (p_data),
        .periph_wr_en_i (p_we),
        .periph_data_o  (regs_o),
        .rd_strobe_o    (rd_stb),
        .wr_strobe_o    (wr_stb),
        .irq_o          (irq)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model state: what each output must hold after the latest edge.
    logic [RC-1:0][DW-1:0] m_regs;
    logic [DW-1:0]         m_rdata;
    logic                  m_rvalid, m_err, m_irq;
    logic [RC-1:0]         m_rds, m_wrs;

    function automatic logic [DW-1:0] next_reg(input int n);
        logic [DW-1:0] v = m_regs[n];
        bit hit = (int'(bus.cpu_addr) == n);
        if (bus.cpu_rd_en && hit) v = v & ~RC_M[n];
        if (p_we[n]) v = p_data[n];
        if (bus.cpu_wr_en && hit)
            for (int b = 0; b < DW/8; b++)
                if (bus.cpu_be[b])
                    for (int k = 0; k < 8; k++)
                        if (RW_M[n][8*b+k]) v[8*b+k] = bus.cpu_wdata[8*b+k];
        return v;
    endfunction

    function automatic logic [DW-1:0] read_value();
        logic [DW-1:0] v = '0;
        for (int n = 0; n < RC; n++)
            if (int'(bus.cpu_addr) == n) v = m_regs[n];
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_regs   <= RST_V;
            m_rdata  <= '0;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            m_rds    <= '0;
            m_wrs    <= '0;
            m_irq    <= 1'b0;
        end else begin
            for (int n = 0; n < RC; n++) m_regs[n] <= next_reg(n);
            m_rvalid <= bus.cpu_rd_en;
            m_err    <= (bus.cpu_rd_en || bus.cpu_wr_en) && (int'(bus.cpu_addr) >= RC);
            if (bus.cpu_rd_en) m_rdata <= read_value();
            m_rds    <= (bus.cpu_rd_en && int'(bus.cpu_addr) < RC) ? RC'(1) << bus.cpu_addr : '0;
            m_wrs    <= (bus.cpu_wr_en && int'(bus.cpu_addr) < RC) ? RC'(1) << bus.cpu_addr : '0;
            m_irq    <= IRQ_ON && (|(m_regs[STAT] & m_regs[IRQ_MASK]));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rdata",  bus.cpu_rdata,  m_rdata);
            check("rvalid", bus.cpu_rvalid, m_rvalid);
            check("err",    bus.cpu_err,    m_err);
            check("rd_stb", rd_stb,         m_rds);
            check("wr_stb", wr_stb,         m_wrs);
            check("irq",    irq,            m_irq);
            for (int n = 0; n < RC; n++)
                check($sformatf("reg%0d", n), regs_o[n], m_regs[n]);
        end
    end

    task automatic idle();
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_be    = '0;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_rd_en = 1'b0;
        p_we          = '0;
        p_data        = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
        bus.cpu_addr  = AW'(a);
        bus.cpu_wdata = d;
        bus.cpu_be    = be;
        bus.cpu_wr_en = 1'b1;
    endtask

    task automatic rd(input int a);
        bus.cpu_addr  = AW'(a);
        bus.cpu_rd_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_reg1",   regs_o[1],      32'h0000_0100);
        check("rst_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_irq",    irq,            1'b0);
        rst_n = 1'b1;

        p_we[1] = 1'b1; p_data[1] = 32'h0; step();
        wr(1, 32'hFFFF_FFFF, 4'b0001); step();
        check("wr_byte0_reg1", regs_o[1], 32'h0000_007F);
        check("wr_stb_pulse",  wr_stb,    6'b000010);
        step();
        check("wr_stb_end",    wr_stb,    6'b000000);

        p_we[0] = 1'b1; p_data[0] = 32'h0001_0001; step();
        rd(0); step();
        check("rc_rdata",  bus.cpu_rdata,  32'h0001_0001);
        check("rc_rvalid", bus.cpu_rvalid, 1'b1);
        check("rc_reg0",   regs_o[0],      32'h0);
        check("rc_rd_stb", rd_stb,         6'b000001);
        step();
        check("hold_rdata", bus.cpu_rdata, 32'h0001_0001);

        p_we[0] = 1'b1; p_data[0] = 32'h0001_0001; step();
        rd(0); p_we[0] = 1'b1; p_data[0] = 32'h1; step();
        check("rcpw_rdata", bus.cpu_rdata, 32'h0001_0001);
        check("rcpw_reg0",  regs_o[0],     32'h1);

        rd(7); step();
        check("bad_rdata",  bus.cpu_rdata,  32'h0);
        check("bad_rvalid", bus.cpu_rvalid, 1'b1);
        check("bad_err",    bus.cpu_err,    1'b1);
        check("bad_rd_stb", rd_stb,         6'b000000);
        wr(6, 32'hFFFF_FFFF, 4'hF); step();
        check("badw_err", bus.cpu_err, 1'b1);

        wr(2, 32'hAB, 4'hF); step();
        rd(2); wr(2, 32'hCD, 4'hF); step();
        check("rw_rdata", bus.cpu_rdata, 32'hAB);
        check("rw_reg2",  regs_o[2],     32'hCD);

        rd(1); step(); check("b2b_1", bus.cpu_rdata, 32'h7F);
        rd(5); step(); check("b2b_5", bus.cpu_rdata, 32'h1B);
        rd(2); step(); check("b2b_2", bus.cpu_rdata, 32'hCD);

        wr(5, 32'h1234_5678, 4'b0110); step();
        check("be_mid_reg5", regs_o[5], 32'h0000_561B);

        rd(0); step();
        wr(4, 32'h1, 4'hF); step();
        p_we[0] = 1'b1; p_data[0] = 32'h1; step();
        check("irq_lag", irq, 1'b0);
        step();
        check("irq_set", irq, IRQ_ON);
        rd(0); step();
        check("irq_hold", irq, IRQ_ON);
        step();
        check("irq_clr", irq, 1'b0);

        rd(1); rst_n = 1'b0; step();
        check("rstrd_rvalid", bus.cpu_rvalid, 1'b0);
        rst_n = 1'b1; step();
        check("rstrd_after", bus.cpu_rvalid, 1'b0);
        check("rstrd_reg1",  regs_o[1],      32'h0000_0100);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
